// File: rtl/pwm_hall_pkg.sv
// rtl/pwm_hall_pkg.sv - register map, response codes and write helpers for the pwm_hall slave
package pwm_hall_pkg;

  // Register word indices (byte address bits [4:2])
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_PERIOD    = 3'd1;
  localparam logic [2:0] REG_DUTY      = 3'd2;
  localparam logic [2:0] REG_HALL_CFG  = 3'd3;
  localparam logic [2:0] REG_HALL_STAT = 3'd4;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // CTRL bit positions
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // HALL_STAT field positions
  localparam int HALL_CNT_LSB = 16;

  // Merge new write data into an existing word under a byte-enable mask
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_hall_pwm_gen.sv
// rtl/pwm_hall_pwm_gen.sv - PWM counter with period/duty shadow registers and registered output
module pwm_hall_pwm_gen
  import pwm_hall_pkg::*;
#(
  parameter int PWM_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [PWM_W-1:0] i_period,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_pwm
);

  localparam logic [PWM_W-1:0] ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_period_sh;
  logic [PWM_W-1:0] r_duty_sh;
  logic             r_pwm;

  // Count 0..period; shadows follow the live registers while disabled and reload only at wrap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_period_sh <= '0;
      r_duty_sh   <= '0;
      r_pwm       <= 1'b0;
    end else if (!i_en) begin
      r_cnt       <= '0;
      r_period_sh <= i_period;
      r_duty_sh   <= i_duty;
      r_pwm       <= 1'b0;
    end else begin
      r_pwm <= (r_cnt < r_duty_sh);
      if (r_cnt == r_period_sh) begin
        r_cnt       <= '0;
        r_period_sh <= i_period;
        r_duty_sh   <= i_duty;
      end else begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_hall_axil_slave.sv
// rtl/pwm_hall_axil_slave.sv - AXI4-Lite slave holding PWM/Hall registers; BYTE_STROBE_EN enables WSTRB byte gating
module pwm_hall_axil_slave
  import pwm_hall_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int PWM_W              = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          pwm_o,
  input  logic [2:0]                    hall_i
);

  logic        r_awready;
  logic        r_bvalid;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        r_ctrl_en;
  logic [31:0] r_period;
  logic [31:0] r_duty;
  logic [31:0] r_hall_cfg;

  logic [2:0]  r_hall_s1;
  logic [2:0]  r_hall_s2;
  logic [2:0]  r_hall_prev;
  logic [15:0] r_edge_cnt;

  logic        w_wr_start;
  logic        w_wr_en;
  logic        w_rd_start;
  logic        w_rd_en;
  logic [2:0]  w_wr_idx;
  logic [2:0]  w_rd_idx;
  logic [3:0]  w_be;
  logic        w_cnt_clr;
  logic        w_hall_edge;
  logic [31:0] w_rd_val;
  logic        w_unused_ok;

  assign w_wr_idx   = S_AXI_AWADDR[4:2];
  assign w_rd_idx   = S_AXI_ARADDR[4:2];
  assign w_wr_start = S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
  assign w_wr_en    = r_awready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_start = S_AXI_ARVALID && !r_rvalid && !r_arready;
  assign w_rd_en    = r_arready && S_AXI_ARVALID;

`ifdef BYTE_STROBE_EN
  assign w_be        = S_AXI_WSTRB;
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign w_be        = 4'hF;
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WSTRB};
`endif

  assign w_cnt_clr   = w_wr_en && (w_wr_idx == REG_CTRL) && w_be[0] && S_AXI_WDATA[CTRL_CLR_BIT];
  assign w_hall_edge = (r_hall_s2 != r_hall_prev);

  // Write channel: one-cycle ready pulse, then response held until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= w_wr_start;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file update on the write handshake edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ctrl_en  <= 1'b0;
      r_period   <= '0;
      r_duty     <= '0;
      r_hall_cfg <= '0;
    end else if (w_wr_en) begin
      case (w_wr_idx)
        REG_CTRL:     if (w_be[0]) r_ctrl_en <= S_AXI_WDATA[CTRL_EN_BIT];
        REG_PERIOD:   r_period   <= strb_merge(r_period, S_AXI_WDATA, w_be);
        REG_DUTY:     r_duty     <= strb_merge(r_duty, S_AXI_WDATA, w_be);
        REG_HALL_CFG: r_hall_cfg <= strb_merge(r_hall_cfg, S_AXI_WDATA, w_be);
        default:      ;
      endcase
    end
  end

  // Read value mux; sampled into RDATA at the read handshake so same-edge writes are not seen
  always_comb begin
    w_rd_val = '0;
    case (w_rd_idx)
      REG_CTRL:      w_rd_val[CTRL_EN_BIT] = r_ctrl_en;
      REG_PERIOD:    w_rd_val = r_period;
      REG_DUTY:      w_rd_val = r_duty;
      REG_HALL_CFG:  w_rd_val = r_hall_cfg;
      REG_HALL_STAT: w_rd_val = {r_edge_cnt, 13'd0, r_hall_s2};
      default:       w_rd_val = '0;
    endcase
  end

  // Read channel: one-cycle ready pulse, data captured and held until accepted
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_rd_start;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Hall inputs: two-flop synchronizer plus one history stage for edge detection
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_hall_s1   <= '0;
      r_hall_s2   <= '0;
      r_hall_prev <= '0;
    end else begin
      r_hall_s1   <= hall_i;
      r_hall_s2   <= r_hall_s1;
      r_hall_prev <= r_hall_s2;
    end
  end

  // Edge counter wraps naturally; a clear request overrides a coincident edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_edge_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_edge_cnt <= '0;
    end else if (w_hall_edge) begin
      r_edge_cnt <= r_edge_cnt + 16'd1;
    end
  end

  pwm_hall_pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm_gen (
    .i_clk    (ACLK),
    .i_rst    (ARESET),
    .i_en     (r_ctrl_en),
    .i_period (r_period[PWM_W-1:0]),
    .i_duty   (r_duty[PWM_W-1:0]),
    .o_pwm    (pwm_o)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_pwm_hall_axil_slave.sv
// tb/tb_pwm_hall_axil_slave.sv - directed self-checking bench for pwm_hall_axil_slave
module tb_pwm_hall_axil_slave;

  logic        ACLK;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        pwm_o;
  logic [2:0]  hall_i;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit hist [0:8191];

  pwm_hall_axil_slave dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .pwm_o         (pwm_o),
    .hall_i        (hall_i)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // pwm_o history, one sample per negedge
  always @(negedge ACLK) begin
    if (cyc < 8192) hist[cyc] = pwm_o;
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (S_AXI_AWREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("wr_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    t = 0;
    while (S_AXI_BVALID !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("wr_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    check("wr_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int t;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (S_AXI_ARREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("rd_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    t = 0;
    while (S_AXI_RVALID !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("rd_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    check("rd_rresp", {30'd0, S_AXI_RRESP}, 32'd0);
    d = S_AXI_RDATA;
    @(negedge ACLK);
  endtask

  // Returns the history index of the next 0->1 transition on pwm_o
  task automatic find_rise(output int idx);
    int  t;
    bit  prev;
    bit  found;
    prev  = 1'b1;
    found = 1'b0;
    t     = 0;
    while (!found && t < 40) begin
      @(negedge ACLK);
      if (pwm_o && !prev) found = 1'b1;
      prev = pwm_o;
      t++;
    end
    #1;
    idx = cyc - 1;
    check("pwm_rise_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [4:0]  wa [4];
    logic [31:0] wd [4];
    logic [31:0] rd;
    logic [31:0] strb_exp;
    int          r;
    int          t;

    wa[0] = 5'h0C; wd[0] = 32'h0101FFFF;
    wa[1] = 5'h04; wd[1] = 32'hABCD0001;
    wa[2] = 5'h08; wd[2] = 32'hDEAD0011;
    wa[3] = 5'h0C; wd[3] = 32'hBEEF0011;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    hall_i = 3'b000;

    repeat (3) @(negedge ACLK);
    check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
    check("rst_rdata",   S_AXI_RDATA,            32'd0);
    check("rst_pwm",     {31'd0, pwm_o},         32'd0);
    ARESET = 1'b0;

    // Register write/readback
    for (int i = 0; i < 4; i++) begin
      axi_write(wa[i], wd[i], 4'hF);
      axi_read(wa[i], rd);
      check($sformatf("readback_%0d", i), rd, wd[i]);
    end

    // Reserved word: write ignored, reads zero
    axi_write(5'h14, 32'h12345678, 4'hF);
    axi_read(5'h14, rd);
    check("reserved_5", rd, 32'd0);
    axi_read(5'h1C, rd);
    check("reserved_7", rd, 32'd0);

    // Byte-strobe behaviour on HALL_CFG
    axi_write(5'h0C, 32'h00000000, 4'hF);
    axi_write(5'h0C, 32'hFFFFFFFF, 4'b0010);
`ifdef BYTE_STROBE_EN
    strb_exp = 32'h0000FF00;
`else
    strb_exp = 32'hFFFFFFFF;
`endif
    axi_read(5'h0C, rd);
    check("wstrb_hall_cfg", rd, strb_exp);

    // Same-cycle read and write to HALL_CFG: read returns the old value
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    check("same_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    check("same_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("same_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    check("same_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    check("same_old_data", S_AXI_RDATA, strb_exp);
    @(negedge ACLK);
    axi_read(5'h0C, rd);
    check("same_new_data", rd, 32'hCAFEF00D);

    // PWM: period 9, duty 3 -> 3 high, 7 low
    axi_write(5'h04, 32'd9, 4'hF);
    axi_write(5'h08, 32'd3, 4'hF);
    axi_write(5'h00, 32'd1, 4'hF);
    axi_read(5'h00, rd);
    check("ctrl_readback", rd, 32'd1);
    find_rise(r);
    repeat (22) @(negedge ACLK);
    for (int i = 0; i < 20; i++)
      check($sformatf("pwm_d3_%0d", i), {31'd0, hist[r+i]}, {31'd0, ((i % 10) < 3)});

    // Duty change mid-period takes effect only from the next wrap
    find_rise(r);
    axi_write(5'h08, 32'd5, 4'hF);
    repeat (25) @(negedge ACLK);
    for (int i = 0; i < 20; i++)
      check($sformatf("pwm_d5_%0d", i), {31'd0, hist[r+i]},
            {31'd0, ((i < 3) || (i >= 10 && i < 15))});

    // Hall: three toggles, then clear
    hall_i = 3'b001;
    repeat (10) @(negedge ACLK);
    hall_i = 3'b011;
    repeat (10) @(negedge ACLK);
    hall_i = 3'b111;
    repeat (2) @(negedge ACLK);
    axi_read(5'h10, rd);
    check("hall_stat_3", rd, 32'h0003_0007);
    axi_write(5'h00, 32'h3, 4'hF);
    axi_read(5'h10, rd);
    check("hall_stat_clr", rd, 32'h0000_0007);
    axi_read(5'h00, rd);
    check("ctrl_clr_reads0", rd, 32'd1);

    // Write response backpressure blocks a second write
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h11112222; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    t = 0;
    while (S_AXI_AWREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("bp_aw1", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(negedge ACLK);
    S_AXI_WDATA = 32'h33334444;
    check("bp_bvalid_up", {31'd0, S_AXI_BVALID}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check($sformatf("bp_hold_bvalid_%0d", k), {31'd0, S_AXI_BVALID}, 32'd1);
      check($sformatf("bp_no_awready_%0d", k), {31'd0, S_AXI_AWREADY}, 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("bp_bvalid_drop", {31'd0, S_AXI_BVALID}, 32'd0);
    t = 0;
    while (S_AXI_AWREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("bp_aw2", {31'd0, S_AXI_AWREADY}, 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    axi_read(5'h0C, rd);
    check("bp_second_data", rd, 32'h33334444);

    // Reset asserted while a read response is pending
    hall_i = 3'b000;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (S_AXI_ARREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rst_pre_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    check("rst_pre_rdata", S_AXI_RDATA, 32'h33334444);
    t = 0;
    while (pwm_o !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    check("rst_pre_pwm", {31'd0, pwm_o}, 32'd1);
    ARESET = 1'b1;
    #1;
    check("rst_mid_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
    check("rst_mid_rdata", S_AXI_RDATA, 32'd0);
    check("rst_mid_pwm", {31'd0, pwm_o}, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), rd);
      check($sformatf("post_rst_word_%0d", i), rd, 32'd0);
    end
    check("post_rst_pwm", {31'd0, pwm_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
